// File: rtl/uart_tx.sv
// UART transmitter: drains the TX FIFO and sends 8N1-style frames LSB first,
// with back-to-back frames and no idle gap between them.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] fifo_rdata,
  input  logic                 fifo_empty,
  output logic                 fifo_ren,
  output logic                 txd,
  output logic                 busy
);

  localparam int BAUD_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int NEXT_IDX = (DATA_BITS > 1) ? 1 : 0;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 bit_end;
  logic                 frame_end;

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign frame_end = (state == STOP) && bit_end && (stop_cnt == STOP_LAST);

  // Pop from idle, or in the last stop cycle so the next start bit follows with no gap.
  assign fifo_ren = ~rst & ~fifo_empty & ((state == IDLE) | frame_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      if (state == IDLE || bit_end)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + BAUD_W'(1);

      case (state)
        IDLE: begin
          if (fifo_ren) begin
            state <= START;
            shreg <= fifo_rdata;
            txd   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
            txd     <= shreg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == BIT_LAST) begin
              state    <= STOP;
              stop_cnt <= 1'b0;
              txd      <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              shreg   <= shreg >> 1;
              txd     <= shreg[NEXT_IDX];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop_cnt == STOP_LAST) begin
              if (fifo_ren) begin
                state <= START;
                shreg <= fifo_rdata;
                txd   <= 1'b0;
              end else begin
                state <= IDLE;
                txd   <= 1'b1;
                busy  <= 1'b0;
              end
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
